// File: rtl/skw_pkg.sv
// Shared types and helpers for the Skolem witness checker harness.
package skw_pkg;

  localparam int unsigned W     = 4;
  localparam int unsigned N_VEC = 2 ** (2 * W);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SWEEP,
    JUDGE,
    DONE
  } skw_state_t;

  // Signed greater-than on W-bit two's-complement operands.
  function automatic logic sgt(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/skw_urem_sgt_eval.sv
// Combinational ev(x,s,t) = (x urem s) >s t, with x urem 0 = x.
module skw_urem_sgt_eval
  import skw_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         hit
);

  logic [W-1:0] r;

  always_comb begin
    r   = (s == '0) ? x : (x % s);
    hit = sgt(r, t);
  end

endmodule

// File: rtl/skolem_witness_checker.sv
// Sweeps all (s,t) pairs into the Skolem netlist and judges each captured witness.
// Optional macro SKW_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module skolem_witness_checker #(
  parameter int unsigned W      = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   sk_s,
  output logic [W-1:0]   sk_t,
  input  logic [W-1:0]   sk_x,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   fail_count,
  output logic [2*W:0]   sat_count,
  output logic           first_fail_valid,
  output logic [W-1:0]   first_fail_s,
  output logic [W-1:0]   first_fail_t,
  output logic [W-1:0]   first_fail_x
);

  import skw_pkg::*;

  localparam int unsigned IW = 2 * W;
  localparam int unsigned CW = IW + 1;

  skw_state_t     state;
  logic [IW-1:0]  idx;
  logic [3:0]     settle_cnt;
  logic [W-1:0]   xc;
  logic [W-1:0]   wit_q;
  logic           exists_q;

  logic           sweep_hit;
  logic           wit_hit;
  logic           vec_fail;
  logic           last_vec;
  logic [CW-1:0]  fail_count_next;

  // Stimulus comes straight from the registered vector index.
  assign sk_s = idx[W-1:0];
  assign sk_t = idx[IW-1:W];

  skw_urem_sgt_eval u_sweep_eval (
    .x   (xc),
    .s   (sk_s),
    .t   (sk_t),
    .hit (sweep_hit)
  );

  skw_urem_sgt_eval u_wit_eval (
    .x   (wit_q),
    .s   (sk_s),
    .t   (sk_t),
    .hit (wit_hit)
  );

  always_comb begin
    vec_fail        = exists_q & ~wit_hit;
    fail_count_next = fail_count + CW'(vec_fail);
  end

`ifdef SKW_STOP_ON_FAIL_EN
  assign last_vec = (idx == IW'(N_VEC - 1)) || vec_fail;
`else
  assign last_vec = (idx == IW'(N_VEC - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      settle_cnt       <= '0;
      xc               <= '0;
      wit_q            <= '0;
      exists_q         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      sat_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_s     <= '0;
      first_fail_t     <= '0;
      first_fail_x     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx              <= '0;
            settle_cnt       <= '0;
            fail_count       <= '0;
            sat_count        <= '0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_s     <= '0;
            first_fail_t     <= '0;
            first_fail_x     <= '0;
            busy             <= 1'b1;
            state            <= APPLY;
          end
        end

        APPLY: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            wit_q    <= sk_x;
            xc       <= '0;
            exists_q <= 1'b0;
            state    <= SWEEP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        SWEEP: begin
          exists_q <= exists_q | sweep_hit;
          xc       <= xc + 1'b1;
          if (xc == '1) begin
            state <= JUDGE;
          end
        end

        JUDGE: begin
          sat_count  <= sat_count + CW'(exists_q);
          fail_count <= fail_count_next;
          if (vec_fail && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_s     <= sk_s;
            first_fail_t     <= sk_t;
            first_fail_x     <= wit_q;
          end
          if (last_vec) begin
            done  <= 1'b1;
            pass  <= (fail_count_next == '0);
            state <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            settle_cnt <= '0;
            state      <= APPLY;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_witness_checker.sv
// Directed bench: drives two checkers (SETTLE=2 and SETTLE=1) from behavioural Skolem netlists.
module tb_skolem_witness_checker;

  localparam int M_CORRECT = 0;
  localparam int M_STUCK0  = 1;
  localparam int M_PLUS1   = 2;

  logic clk = 1'b0;
  logic rst_n, start, sel;
  int   wmode;
  int   checks = 0;
  int   errors = 0;
  int   done_at;

  logic [3:0] sk_s0, sk_t0, x0, ffs0, fft0, ffx0;
  logic [3:0] sk_s1, sk_t1, x1, ffs1, fft1, ffx1;
  logic       busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
  logic [8:0] fc0, sc0, fc1, sc1;
  logic       start0, start1;

  logic [3:0] m_sk_s, m_sk_t, m_ffs, m_fft, m_ffx;
  logic       m_busy, m_done, m_pass, m_ffv;
  logic [8:0] m_fc, m_sc;

  int e_sat, e_fail, e_visits, e_ffv, e_ffs, e_fft, e_ffx;

  always #5 clk = ~clk;

  function automatic int sgn(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  function automatic bit ev_m(input int x, input int s, input int t);
    int r;
    r = (s == 0) ? x : x % s;
    return sgn(r) > sgn(t);
  endfunction

  function automatic logic [3:0] witness(input int m, input logic [3:0] s, input logic [3:0] t);
    int w;
    w = 0;
    for (int x = 15; x >= 0; x--)
      if (ev_m(x, int'(s), int'(t))) w = x;
    if (m == M_STUCK0) w = 0;
    else if (m == M_PLUS1) w = (w + 1) % 16;
    return 4'(w);
  endfunction

  always_comb x0 = witness(wmode, sk_s0, sk_t0);
  always_comb x1 = witness(wmode, sk_s1, sk_t1);

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  skolem_witness_checker #(.W(4), .SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sk_s(sk_s0), .sk_t(sk_t0), .sk_x(x0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0), .sat_count(sc0),
    .first_fail_valid(ffv0), .first_fail_s(ffs0), .first_fail_t(fft0), .first_fail_x(ffx0)
  );

  skolem_witness_checker #(.W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sk_s(sk_s1), .sk_t(sk_t1), .sk_x(x1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .sat_count(sc1),
    .first_fail_valid(ffv1), .first_fail_s(ffs1), .first_fail_t(fft1), .first_fail_x(ffx1)
  );

  always_comb begin
    m_sk_s = sel ? sk_s1 : sk_s0;
    m_sk_t = sel ? sk_t1 : sk_t0;
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
    m_pass = sel ? pass1 : pass0;
    m_fc   = sel ? fc1   : fc0;
    m_sc   = sel ? sc1   : sc0;
    m_ffv  = sel ? ffv1  : ffv0;
    m_ffs  = sel ? ffs1  : ffs0;
    m_fft  = sel ? fft1  : fft0;
    m_ffx  = sel ? ffx1  : ffx0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compute_model(input int m);
    bit ex, fl;
    e_sat = 0; e_fail = 0; e_visits = 0; e_ffv = 0; e_ffs = 0; e_fft = 0; e_ffx = 0;
    for (int v = 0; v < 256; v++) begin
      int s, t, w;
      s = v % 16;
      t = v / 16;
      ex = 1'b0;
      for (int x = 0; x < 16; x++) ex |= ev_m(x, s, t);
      w  = int'(witness(m, 4'(s), 4'(t)));
      fl = ex && !ev_m(w, s, t);
      e_visits = v + 1;
      if (ex) e_sat++;
      if (fl) begin
        e_fail++;
        if (e_ffv == 0) begin
          e_ffv = 1; e_ffs = s; e_fft = t; e_ffx = w;
        end
`ifdef SKW_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_counts"}, 32'({m_fc, m_sc}), 32'd0);
    chk({name, "_flags"}, 32'({m_sk_s, m_sk_t, m_busy, m_done, m_pass, m_ffv, m_ffs, m_fft, m_ffx}), 32'd0);
  endtask

  // Walks the sweep cycle by cycle against the latency/index timeline, then checks results.
  task automatic run_sweep(input int m, input bit poke, input int abort_vec);
    int settle, per, lat;
    settle  = sel ? 1 : 2;
    per     = settle + 17;
    done_at = -1;
    compute_model(m);
    lat   = e_visits * per;
    wmode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= lat + 2; k++) begin
      if (abort_vec >= 0 && k == abort_vec * per + settle + 5) begin
        chk("abort_point_sk_s", 32'(m_sk_s), 32'(abort_vec % 16));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk); #1;
        check_all_zero("held_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("after_reset");
        return;
      end
      chk("busy", 32'(m_busy), 32'(k <= lat));
      chk("done", 32'(m_done), 32'(k == lat));
      if (m_done === 1'b1 && done_at < 0) done_at = k;
      if (k < lat) begin
        chk("sk_s", 32'(m_sk_s), 32'((k / per) % 16));
        chk("sk_t", 32'(m_sk_t), 32'((k / per) / 16));
      end
      if (k == lat) chk("pass_at_done", 32'(m_pass), 32'(e_fail == 0));
      start = poke && (k == 5 || k == 100 || k == lat);
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pass", 32'(m_pass), 32'(e_fail == 0));
    chk("fail_count", 32'(m_fc), 32'(e_fail));
    chk("sat_count", 32'(m_sc), 32'(e_sat));
    chk("first_fail_valid", 32'(m_ffv), 32'(e_ffv));
    chk("first_fail_s", 32'(m_ffs), 32'(e_ffs));
    chk("first_fail_t", 32'(m_fft), 32'(e_fft));
    chk("first_fail_x", 32'(m_ffx), 32'(e_ffx));
  endtask

  task automatic pin_correct(input int exp_done_at);
    chk("lit_done_at", 32'(done_at), 32'(exp_done_at));
    chk("lit_pass", 32'(m_pass), 32'd1);
    chk("lit_fail_count", 32'(m_fc), 32'd0);
    chk("lit_sat_count", 32'(m_sc), 32'd212);
    chk("lit_ffv", 32'(m_ffv), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    wmode = M_CORRECT;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset0");
    sel = 1'b1;
    check_all_zero("reset1");
    sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_sweep(M_CORRECT, 1'b0, -1);
    pin_correct(4864);

    run_sweep(M_STUCK0, 1'b0, -1);
`ifdef SKW_STOP_ON_FAIL_EN
    chk("lit_s0_done_at", 32'(done_at), 32'd19);
    chk("lit_s0_fail_count", 32'(m_fc), 32'd1);
    chk("lit_s0_sat_count", 32'(m_sc), 32'd1);
`else
    chk("lit_s0_done_at", 32'(done_at), 32'd4864);
    chk("lit_s0_fail_count", 32'(m_fc), 32'd84);
    chk("lit_s0_sat_count", 32'(m_sc), 32'd212);
`endif
    chk("lit_s0_pass", 32'(m_pass), 32'd0);
    chk("lit_s0_ff", 32'({m_ffv, m_ffs, m_fft, m_ffx}), 32'h1000);

    run_sweep(M_STUCK0, 1'b0, 37);
    run_sweep(M_CORRECT, 1'b1, -1);
    pin_correct(4864);

    run_sweep(M_PLUS1, 1'b0, -1);

    sel = 1'b1;
    @(posedge clk); #1;
    run_sweep(M_CORRECT, 1'b0, -1);
    pin_correct(4608);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skolem_witness_checker.md
Name: skolem_witness_checker

Overview:
- Sequential harness that sits directly downstream of the 4-bit find_inv bvsgt/bvurem0 Skolem-function netlist.
- Sweeps all 256 (s,t) stimulus pairs into the netlist and captures its witness x for each.
- Exhaustively decides whether any x satisfies (x urem s) >s t, and flags vectors where a witness exists but the captured one fails.
- Reports pass/fail, counts and the first failing vector.

Parameters:
- W, 4: operand width; only 4 is supported, 2**(2W) stimulus vectors.
- SETTLE, 2: cycles the stimulus is held before the witness is sampled; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a sweep; ignored unless IDLE.
- sk_s  out  W  s operand to netlist inputs i0..i3 (bit0 = i0).
- sk_t  out  W  t operand to netlist inputs i4..i7 (bit0 = i4).
- sk_x  in  W  witness from netlist outputs i8..i11 (bit0 = i8).
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  valid from done onward; 1 iff fail_count==0.
- fail_count  out  9  vectors where a witness exists but sk_x does not satisfy the condition.
- sat_count  out  9  vectors where some x satisfies the condition.
- first_fail_valid  out  1  set on the first failure.
- first_fail_s, first_fail_t, first_fail_x  out  W each  operands of the first failure.

Behaviour:
- Reset: all outputs 0, state IDLE, vector index idx=0. Asserting rst_n mid-sweep aborts immediately; no partial results are retained.
- Stimulus index: idx is 8 bits, with sk_s=idx[3:0] and sk_t=idx[7:4], both registered outputs.
- Evaluation ev(x,s,t):
  - r = x urem s, with r = x when s==0 (SMT-LIB semantics).
  - Result is 1 iff r > t as 4-bit two's-complement.
- FSM states: IDLE, APPLY, SWEEP, JUDGE, DONE.
- IDLE:
  - On start, clear counters, first_fail_*, pass and idx, then go to APPLY.
  - busy rises next cycle.
- APPLY:
  - Hold sk_s/sk_t for SETTLE cycles.
  - On the last cycle, register sk_x into wit_q.
  - Go to SWEEP.
- SWEEP:
  - 16 cycles with xc = 0..15; exists_q |= ev(xc,s,t).
  - exists_q is cleared on SWEEP entry.
- JUDGE (1 cycle):
  - hold = ev(wit_q,s,t).
  - sat_count += exists_q.
  - On fail (exists_q & ~hold):
    - fail_count++.
    - If !first_fail_valid, latch s, t, wit_q and set first_fail_valid.
  - If idx==255 go to DONE; otherwise idx++ and go to APPLY.
- DONE:
  - done=1 for one cycle, pass = (fail_count_next==0), then IDLE.
  - Results hold until the next accepted start.
- Latency: per vector SETTLE+17 cycles. If start is sampled at edge N, done is high in cycle N+1+256*(SETTLE+17); with SETTLE=2 that is N+4865.
- Counters are 9 bits and cannot wrap (maximum 256).
- start while busy has no effect. start in the DONE cycle is ignored.

Optional Feature:
- Macro SKW_STOP_ON_FAIL_EN.
- When defined, JUDGE with a failure goes straight to DONE after updating counters and first_fail_*. fail_count is then ≤1 and sat_count covers only the vectors visited.
- When undefined, the full 256-vector sweep always runs.

Decomposition:
- Package skw_pkg holds:
  - W and N_VEC=256.
  - State enum skw_state_t {IDLE, APPLY, SWEEP, JUDGE, DONE}.
  - A function for signed 4-bit compare.
- Sub-module skw_urem_sgt_eval: combinational ev(x,s,t), instantiated twice (sweep path, witness path).

Test Plan:
- Correct Skolem netlist attached, start pulse -> done at start+4865, pass=1, fail_count=0, sat_count=212, first_fail_valid=0.
- Witness stuck at 4'b0000 -> fail_count=84, sat_count=212, pass=0, first_fail_s=0, first_fail_t=0, first_fail_x=0.
- Stuck-zero witness with SKW_STOP_ON_FAIL_EN -> done 20 cycles after start, fail_count=1, sat_count=1, first_fail at (0,0,0).
- rst_n pulsed low during SWEEP of vector 37 -> all outputs 0 asynchronously; new start gives results identical to the first scenario.
- start re-pulsed at cycles 5 and 100 of a sweep -> ignored; done timing and counts unchanged.
- SETTLE=1 build, correct netlist -> done at start+1+256*18 = start+4609, pass=1.
